// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and key-schedule helpers for the AES-128 round-key scheduler.
package aes_pkg;

    localparam int unsigned NB = 4;
    localparam int unsigned NK = 4;
    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_EMIT
    } ks_state_e;

    // Round constant byte for round k (1..10); other indices never reach the datapath.
    function automatic logic [7:0] rcon_byte(input logic [3:0] k);
        case (k)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box lookup, purely combinational.
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_round_key_sched.sv
// On-the-fly AES-128 round-key scheduler: one round key per cycle, forward or reverse order.
// Optional macro AES_KS_STALL_CNT_EN adds a saturating stall_cnt output.
module aes_round_key_sched #(
    parameter int unsigned NR    = 10,
    parameter int unsigned RND_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dir,
    input  logic [0:127]     key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [0:127]     rk_data,
    output logic [RND_W-1:0] rk_round,
    output logic             rk_last,
    output logic             busy,
    output logic             done
`ifdef AES_KS_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    import aes_pkg::*;

    ks_state_e        state_q, state_d;
    logic [127:0]     data_q, data_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             step_fwd;
    logic [31:0]      w0, w1, w2, w3;
    logic [31:0]      w1r, w2r, w3r;
    logic [31:0]      f0, f1, f2, f3;
    logic [31:0]      sub_in, sub_out, t_word;
    logic [RND_W-1:0] rc_idx;
    logic [127:0]     step_data;
    logic [RND_W-1:0] step_round;

    assign xfer     = valid_q && rk_ready;
    // PREP always runs the forward recurrence, even for a reverse sequence.
    assign step_fwd = (state_q == ST_PREP) || !dir_q;

    assign w0  = data_q[127:96];
    assign w1  = data_q[95:64];
    assign w2  = data_q[63:32];
    assign w3  = data_q[31:0];
    assign w3r = w3 ^ w2;
    assign w2r = w2 ^ w1;
    assign w1r = w1 ^ w0;

    // One SubWord serves both directions: forward uses w3, reverse uses the recovered w3'.
    assign sub_in = rot_word(step_fwd ? w3 : w3r);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (sub_in[8*i +: 8]),
            .byte_o (sub_out[8*i +: 8])
        );
    end

    assign rc_idx = step_fwd ? round_q + RND_W'(1) : round_q;
    assign t_word = sub_out ^ {rcon_byte(4'(rc_idx)), 24'h0};

    assign f0 = w0 ^ t_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign step_data  = step_fwd ? {f0, f1, f2, f3} : {w0 ^ t_word, w1r, w2r, w3r};
    assign step_round = step_fwd ? round_q + RND_W'(1) : round_q - RND_W'(1);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        round_d = round_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        if (load) begin
            data_d  = key;
            round_d = '0;
            dir_d   = dir;
            valid_d = !dir;
            state_d = dir ? ST_PREP : ST_EMIT;
        end else begin
            case (state_q)
                ST_PREP: begin
                    data_d  = step_data;
                    round_d = step_round;
                    if (step_round == RND_W'(NR)) begin
                        valid_d = 1'b1;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (xfer) begin
                        if (last_q) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            data_d  = step_data;
                            round_d = step_round;
                        end
                    end
                end
                default: ;
            endcase
        end

        last_d = dir_d ? (round_d == '0) : (round_d == RND_W'(NR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            round_q <= round_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = valid_q;
    assign rk_data  = data_q;
    assign rk_round = round_q;
    assign rk_last  = last_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

`ifdef AES_KS_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (load) begin
            stall_d = '0;
        end else if (valid_q && !rk_ready && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_aes_round_key_sched.sv
// Self-checking bench for aes_round_key_sched: table-driven runs with a scoreboarded key stream
// from an independent key-expansion model; stall_cnt is checked when AES_KS_STALL_CNT_EN is defined.
module tb_aes_round_key_sched;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         load     = 1'b0;
    logic         dir_in   = 1'b0;
    logic         rk_ready = 1'b0;
    logic [0:127] key_in   = '0;
    logic         rk_valid, rk_last, busy, done;
    logic [0:127] rk_data;
    logic [3:0]   rk_round;
`ifdef AES_KS_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        logic         dir;
        logic         bp;
        int unsigned  lat;
        logic [127:0] first;
        logic [127:0] last;
    } vec_t;

    exp_t         sb [$];
    exp_t         mon_e;
    logic [7:0]   sbox_m [256];
    logic [127:0] rk_m [11];

    aes_round_key_sched #(.NR(10), .RND_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dir      (dir_in),
        .key      (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .busy     (busy),
        .done     (done)
`ifdef AES_KS_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from GF(2^8) inversion plus affine map, independent of any lookup table.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            b   = 8'(x);
            inv = '0;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called just after a rising edge; returns just after the edge that samples load.
    task automatic drive_load(input logic [127:0] k, input logic d);
        expand(k);
        sb.delete();
        for (int j = 0; j <= 10; j++) begin
            int r;
            r = d ? 10 - j : j;
            sb.push_back('{rk_m[r], 4'(r), (j == 10)});
        end
        key_in = k;
        dir_in = d;
        load   = 1'b1;
        @(posedge clk); #1;
        load   = 1'b0;
    endtask

    task automatic finish_seq(input string nm, input bit bp, input int unsigned exp_lat,
                              input logic [127:0] exp_first, input logic [127:0] exp_last);
        int unsigned  lat, nvalid, dones, not_busy;
        logic [127:0] first_k, last_k;
        lat = 1; nvalid = 0; dones = 0; not_busy = 0;
        while (!rk_valid && lat < 40) begin
            if (done) dones++;
            if (!busy) not_busy++;
            rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("%s latency", nm), lat, exp_lat);
        if (exp_lat > 1) begin
            chk($sformatf("%s done during prep", nm), dones, 0);
            chk($sformatf("%s busy during prep", nm), not_busy, 0);
        end
        first_k = rk_data;
        last_k  = rk_data;
        while (rk_valid && nvalid < 200) begin
            rk_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            last_k   = rk_data;
            nvalid++;
            @(posedge clk); #1;
        end
        chk($sformatf("%s first key", nm), first_k, exp_first);
        chk($sformatf("%s last key", nm), last_k, exp_last);
        if (!bp) chk($sformatf("%s valid run length", nm), nvalid, 11);
        chk($sformatf("%s done pulse", nm), done, 1'b1);
        chk($sformatf("%s keys outstanding", nm), sb.size(), 0);
        @(posedge clk); #1;
        chk($sformatf("%s done single cycle", nm), done, 1'b0);
        chk($sformatf("%s idle busy", nm), busy, 1'b0);
        rk_ready = 1'b0;
    endtask

    task automatic reset_chk(input string nm);
        chk($sformatf("%s rk_valid", nm), rk_valid, 1'b0);
        chk($sformatf("%s rk_data", nm), rk_data, 128'h0);
        chk($sformatf("%s rk_round", nm), rk_round, 4'h0);
        chk($sformatf("%s rk_last", nm), rk_last, 1'b0);
        chk($sformatf("%s busy", nm), busy, 1'b0);
        chk($sformatf("%s done", nm), done, 1'b0);
`ifdef AES_KS_STALL_CNT_EN
        chk($sformatf("%s stall_cnt", nm), stall_cnt, 16'h0);
`endif
    endtask

    logic         hold_pend = 1'b0;
    logic [127:0] hold_data;
    logic [3:0]   hold_round;

    // Transfers happen at the next rising edge; inputs are stable from the previous edge +1.
    always @(negedge clk) begin
        if (rst || load || !rk_valid) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                chk("stall data stable", rk_data, hold_data);
                chk("stall round stable", rk_round, hold_round);
            end
            if (rk_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected transfer: round %0d data %h with no key expected", rk_round, rk_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("stream key", rk_data, mon_e.data);
                    chk("stream round", rk_round, mon_e.round);
                    chk("stream last", rk_last, mon_e.last);
                end
                hold_pend <= 1'b0;
            end else begin
                hold_pend  <= 1'b1;
                hold_data  <= rk_data;
                hold_round <= rk_round;
            end
        end
    end

    initial begin
        vec_t        vecs [5];
        int unsigned guard, dones;

        vecs[0] = '{FIPS_KEY, 1'b0, 1'b0, 1,  FIPS_KEY, FIPS_R10};
        vecs[1] = '{FIPS_KEY, 1'b1, 1'b0, 11, FIPS_R10, FIPS_KEY};
        vecs[2] = '{ZERO_KEY, 1'b0, 1'b0, 1,  ZERO_KEY, ZERO_R10};
        vecs[3] = '{ZERO_KEY, 1'b1, 1'b0, 11, ZERO_R10, ZERO_KEY};
        vecs[4] = '{FIPS_KEY, 1'b0, 1'b1, 1,  FIPS_KEY, FIPS_R10};

        build_sbox();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_chk("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_load(vecs[i].key, vecs[i].dir);
            finish_seq($sformatf("vec%0d", i), vecs[i].bp, vecs[i].lat, vecs[i].first, vecs[i].last);
        end

        // Restart in EMIT at round 5 with a new key in reverse.
        drive_load(FIPS_KEY, 1'b0);
        rk_ready = 1'b1;
        guard = 0;
        dones = 0;
        while (!(rk_valid && rk_round == 4'd5) && guard < 40) begin
            if (rk_valid && rk_round == 4'd1) chk("fips round 1", rk_data, FIPS_R1);
            if (done) dones++;
            @(posedge clk); #1;
            guard++;
        end
        chk("restart reached round 5", rk_round, 4'd5);
        chk("restart no early done", dones, 0);
        drive_load(ZERO_KEY, 1'b1);
        finish_seq("restart", 1'b0, 11, ZERO_R10, ZERO_KEY);

        // Reset asserted in the fourth PREP cycle.
        drive_load(FIPS_KEY, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("prep round before reset", rk_round, 4'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_chk("mid-prep reset");
        sb.delete();
        drive_load(FIPS_KEY, 1'b1);
        finish_seq("after reset", 1'b0, 11, FIPS_R10, FIPS_KEY);

`ifdef AES_KS_STALL_CNT_EN
        drive_load(FIPS_KEY, 1'b0);
        rk_ready = 1'b1;
        guard = 0;
        while (!(rk_valid && rk_round == 4'd3) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        rk_ready = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("stall_cnt after 7 stalls", stall_cnt, 16'd7);
        chk("stalled round", rk_round, 4'd3);
        finish_seq("stall run", 1'b1, 1, rk_m[3], FIPS_R10);
        drive_load(ZERO_KEY, 1'b0);
        chk("stall_cnt cleared by load", stall_cnt, 16'd0);
        finish_seq("post-stall run", 1'b0, 1, ZERO_KEY, ZERO_R10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: time limit reached before the test completed");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_round_key_sched.md
Name: aes_round_key_sched

Overview:
- On-the-fly AES-128 round-key scheduler that replaces full up-front expansion with one 128-bit round key per cycle.
- Feeds the round datapath through a valid/ready stream.
  - Forward order (rounds 0..NR) for encryption.
  - Reverse order (rounds NR..0) for decryption, using the inverse key recurrence.
- Sits between the key input register and the AES round controller; holds only the current round key, not all 11.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- RND_W, 4, width of the round index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle start pulse; samples key and dir.
- dir  in  1  0 = forward (encrypt), 1 = reverse (decrypt).
- key  in  128 [0:127]  cipher key, byte 0 in bits [0:7].
- rk_valid  out  1  rk_data holds a valid round key.
- rk_ready  in  1  consumer accepts rk_data this cycle.
- rk_data  out  128 [0:127]  current round key (words w0..w3).
- rk_round  out  RND_W  round index of rk_data.
- rk_last  out  1  high with the final key of the sequence (round NR in forward, 0 in reverse).
- busy  out  1  high in PREP or EMIT.
- done  out  1  one-cycle pulse in the cycle after the last transfer.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: rk_valid=0, rk_data=0, rk_round=0, rk_last=0, busy=0, done=0, state=IDLE.
- Transfer: occurs when rk_valid && rk_ready are both high on a rising edge.
- Forward step (round r -> r+1), all combinational in one cycle:
  - T = SubWord(RotWord(w3)) ^ Rcon(r+1)
  - w0' = w0^T; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- Reverse step (round r -> r-1):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(r)
- Rcon(k) = {rc[k],24'h0}, with rc = 01,02,04,08,10,20,40,80,1b,36 for k=1..10.
- States: IDLE, PREP, EMIT.
- IDLE:
  - On load with dir=0: rk_data<=key, rk_round<=0, rk_valid<=1, go EMIT. First key is valid 1 cycle after load.
  - On load with dir=1: rk_data<=key, rk_round<=0, go PREP.
- PREP:
  - Applies the forward step once per cycle with rk_valid=0.
  - When rk_round reaches NR: rk_valid<=1 and go EMIT. First key (round 10) is valid NR+1 cycles after load.
- EMIT:
  - On transfer with rk_last=0: apply the step in the current direction and update rk_round (+1 forward, -1 reverse). rk_valid stays 1, so a held-high rk_ready gives one key per cycle with no bubbles.
  - On transfer with rk_last=1: rk_valid<=0, done<=1 for one cycle, go IDLE.
- No transfer: rk_data, rk_round and rk_last hold stable while rk_valid=1 (stall).
- rk_last is registered alongside rk_round and equals (dir_q ? rk_round==0 : rk_round==NR).
- load in PREP or EMIT aborts the current sequence and restarts with the new key and dir, exactly as from IDLE. No done pulse is issued for the aborted sequence.
- load has priority over a same-cycle transfer.
- rst in any state returns to the reset values on the next edge.
- rk_ready is ignored while rk_valid=0.

Optional Feature:
- Macro: AES_KS_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments each cycle with rk_valid && !rk_ready and saturates at 16'hFFFF.
  - Clears on load and on rst.
  - Intended for side-channel and throughput study.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Package aes_pkg holds:
  - NB=4, NK=4, NR=10 constants.
  - The Rcon byte table or function.
  - State encoding for IDLE/PREP/EMIT.
  - RotWord as a shared function.
- Sub-module aes_sbox: single-byte S-box lookup, instantiated 4 times.
  - Its input is muxed between w3 (forward step) and w3' (reverse step), so the forward and reverse paths share one SubWord.

Test Plan:
- Forward, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready tied 1:
  - Round 0 = key 1 cycle after load.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
  - done pulses in the following cycle; 11 consecutive valid cycles with no bubbles.
- Reverse, same key:
  - busy=1 and rk_valid=0 for 10 cycles.
  - Then round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, descending to round 0 = key with rk_last=1.
- Backpressure: rk_ready toggled randomly in forward mode.
  - rk_data and rk_round stay stable during stalls.
  - The key sequence is identical to the no-stall run.
- Restart in EMIT: load with a new key and dir=1 at round 5.
  - No done pulse for the aborted run.
  - The new reverse sequence starts correctly after 10 PREP cycles.
- Reset mid-PREP: rst asserted at PREP cycle 4.
  - Next cycle: all outputs equal their reset values and state is IDLE.
  - A subsequent load runs normally.
- With AES_KS_STALL_CNT_EN: hold rk_ready=0 for 7 cycles at round 3; stall_cnt=7, and it clears on the next load.
